// File: rtl/ysyx_22051013_mdu_seq.sv
// RV64M multiply/divide sequencer: one op per handshake on a shared 1-bit/cycle
// shift-add multiplier / restoring divider, with RISC-V special-case handling.
module ysyx_22051013_mdu_seq #(
   parameter int XLEN = 64
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic [3:0]      i_req_op,
   input  logic [XLEN-1:0] i_src1,
   input  logic [XLEN-1:0] i_src2,
   input  logic            i_flush,
   output logic            o_resp_valid,
   input  logic            i_resp_ready,
   output logic [XLEN-1:0] o_result,
   output logic            o_busy
);
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t        r_state, w_next;
   logic [3:0]    r_op;
   logic          r_word, r_neg;
   logic [5:0]    r_cnt;
   logic [127:0]  r_acc;
   logic [63:0]   r_mcand, r_result;

   logic          w_accept, w_div, w_word, w_zx, w_illegal, w_dz, w_ovf, w_special;
   logic          w_s1, w_s2, w_neg;
   logic [63:0]   w_a, w_b, w_a_s, w_min, w_mag1, w_mag2, w_sres;
   logic [64:0]   w_sum, w_trial;
   logic [127:0]  w_mul_nxt, w_div_nxt, w_prod;
   logic [63:0]   w_qr, w_qrs, w_x;

   // ---- request decode and operand preparation ----
   assign w_div     = i_req_op[2];
   assign w_word    = i_req_op[3];
   assign w_zx      = w_word & w_div & i_req_op[0];
   assign w_illegal = w_word & ~w_div & (i_req_op[1:0] != 2'd0);
   assign w_a_s     = w_word ? {{32{i_src1[31]}}, i_src1[31:0]} : i_src1;
   assign w_a = ~w_word ? i_src1 : (w_zx ? {32'b0, i_src1[31:0]} : {{32{i_src1[31]}}, i_src1[31:0]});
   assign w_b = ~w_word ? i_src2 : (w_zx ? {32'b0, i_src2[31:0]} : {{32{i_src2[31]}}, i_src2[31:0]});

   // MUL/MULW only keep low product bits, which are sign-agnostic, so run them unsigned
   assign w_s1 = w_div ? (~i_req_op[0] & w_a[63])
                       : (~w_word & (i_req_op[1:0] == 2'd1 || i_req_op[1:0] == 2'd2) & w_a[63]);
   assign w_s2 = w_div ? (~i_req_op[0] & w_b[63])
                       : (~w_word & (i_req_op[1:0] == 2'd1) & w_b[63]);
   assign w_neg  = (w_div & i_req_op[1]) ? w_s1 : (w_s1 ^ w_s2);
   assign w_mag1 = w_s1 ? (64'd0 - w_a) : w_a;
   assign w_mag2 = w_s2 ? (64'd0 - w_b) : w_b;

   assign w_min     = w_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
   assign w_dz      = w_div & (w_b == 64'd0);
   assign w_ovf     = w_div & ~i_req_op[0] & (w_a == w_min) & (w_b == {64{1'b1}});
   assign w_special = w_illegal | w_dz | w_ovf;
   assign w_sres    = w_illegal ? 64'd0 :
                      w_dz      ? (i_req_op[1] ? w_a_s : {64{1'b1}}) :
                                  (i_req_op[1] ? 64'd0 : w_a_s);

   assign o_req_ready  = (r_state == S_IDLE) & ~i_flush & ~i_rst;
   assign w_accept     = i_req_valid & o_req_ready;
   assign o_resp_valid = (r_state == S_DONE);
   assign o_busy       = (r_state != S_IDLE);
   assign o_result     = r_result;

   // ---- one iteration of each engine ----
   assign w_sum     = {1'b0, r_acc[127:64]} + (r_acc[0] ? {1'b0, r_mcand} : 65'd0);
   assign w_mul_nxt = {w_sum, r_acc[63:1]};
   // top bit of the shifted remainder is kept so divisors above 2^63 compare correctly
   assign w_trial   = r_acc[127:63] - {1'b0, r_mcand};
   assign w_div_nxt = w_trial[64] ? {r_acc[126:0], 1'b0} : {w_trial[63:0], r_acc[62:0], 1'b1};

   // ---- sign fix and output select ----
   assign w_prod = r_neg ? (128'd0 - r_acc) : r_acc;
   assign w_qr   = r_op[1] ? r_acc[127:64] : r_acc[63:0];
   assign w_qrs  = r_neg ? (64'd0 - w_qr) : w_qr;

   always_comb begin
      w_x = 64'd0;
      if (r_op[2])          w_x = r_word ? {{32{w_qrs[31]}}, w_qrs[31:0]} : w_qrs;
      else if (r_word)      w_x = {{32{w_prod[63]}}, w_prod[63:32]};
      else if (r_op[1:0] == 2'd0) w_x = w_prod[63:0];
      else                  w_x = w_prod[127:64];
   end

   // ---- FSM ----
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_special ? S_DONE : S_CALC;
         S_CALC:  if (r_cnt == 6'd0) w_next = S_FIX;
         S_FIX:   w_next = S_DONE;
         S_DONE:  if (i_resp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (i_flush) w_next = S_IDLE;
   end

   // ---- datapath ----
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_op     <= 4'd0;
         r_word   <= 1'b0;
         r_neg    <= 1'b0;
         r_cnt    <= 6'd0;
         r_acc    <= 128'd0;
         r_mcand  <= 64'd0;
         r_result <= 64'd0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_op   <= i_req_op;
               r_word <= w_word;
               r_neg  <= w_neg;
               r_cnt  <= w_word ? 6'd31 : 6'd63;
               if (w_special) r_result <= w_sres;
               if (w_div) begin
                  // W dividends start in the upper half so 32 shifts reach the remainder
                  r_mcand <= w_mag2;
                  r_acc   <= {64'd0, (w_word ? {w_mag1[31:0], 32'd0} : w_mag1)};
               end else begin
                  r_mcand <= w_mag1;
                  r_acc   <= {64'd0, w_mag2};
               end
            end
            S_CALC: begin
               r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
               r_cnt <= r_cnt - 6'd1;
            end
            S_FIX:   r_result <= w_x;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_22051013_mdu_seq.sv
// Directed table-driven bench for the M-extension sequencer plus handshake,
// flush and reset corner sequences.
module tb_ysyx_22051013_mdu_seq;
   logic        i_clk = 1'b0;
   logic        i_rst, i_req_valid, i_flush, i_resp_ready;
   logic [3:0]  i_req_op;
   logic [63:0] i_src1, i_src2;
   logic        o_req_ready, o_resp_valid, o_busy;
   logic [63:0] o_result;

   int n_total = 0;
   int n_bad   = 0;

   ysyx_22051013_mdu_seq #(.XLEN(64)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_op(i_req_op), .i_src1(i_src1), .i_src2(i_src2), .i_flush(i_flush),
      .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready), .o_result(o_result),
      .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [63:0] a, b, exp;
      int          lat;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called #1 after a rising edge; returns with the response visible, not consumed.
   task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat);
      int g;
      i_req_valid = 1'b1; i_req_op = op; i_src1 = a; i_src2 = b;
      g = 0;
      while (!o_req_ready && g < 20) begin @(posedge i_clk); #1; g++; end
      @(posedge i_clk); #1;
      i_req_valid = 1'b0; i_req_op = 4'd9; i_src1 = 64'hDEAD_BEEF_0BAD_F00D; i_src2 = 64'd0;
      lat = 1;
      while (!o_resp_valid && lat < 200) begin @(posedge i_clk); #1; lat++; end
      res = o_result;
   endtask

   task automatic take();
      i_resp_ready = 1'b1;
      @(posedge i_clk); #1;
      i_resp_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] res;
      int lat;
      int seen;

      tbl[0]  = '{"MUL 3*-5",     4'd0,  64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 66};
      tbl[1]  = '{"MULHU ones",   4'd3,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66};
      tbl[2]  = '{"MULH min*min", 4'd1,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 66};
      tbl[3]  = '{"DIV -7/2",     4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
      tbl[4]  = '{"REM -7/2",     4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
      tbl[5]  = '{"DIVU 100/7",   4'd5,  64'd100, 64'd7, 64'd14, 66};
      tbl[6]  = '{"REMU 100/7",   4'd7,  64'd100, 64'd7, 64'd2, 66};
      tbl[7]  = '{"DIVU 5/0",     4'd5,  64'd5, 64'd0, '1, 1};
      tbl[8]  = '{"REM 5/0",      4'd6,  64'd5, 64'd0, 64'd5, 1};
      tbl[9]  = '{"DIV ovf",      4'd4,  64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
      tbl[10] = '{"REM ovf",      4'd6,  64'h8000_0000_0000_0000, '1, 64'd0, 1};
      tbl[11] = '{"DIVW ovf",     4'd12, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
      tbl[12] = '{"REMUW",        4'd15, 64'h0000_0001_0000_0007, 64'd3, 64'd1, 34};
      tbl[13] = '{"MULW",         4'd8,  64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34};
      tbl[14] = '{"illegal op10", 4'd10, 64'd55, 64'd66, 64'd0, 1};

      i_rst = 1'b1; i_req_valid = 1'b0; i_flush = 1'b0; i_resp_ready = 1'b0;
      i_req_op = 4'd0; i_src1 = 64'd0; i_src2 = 64'd0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("reset req_ready", {63'd0, o_req_ready}, 64'd0);
      chk("reset busy", {63'd0, o_busy}, 64'd0);
      chk("reset resp_valid", {63'd0, o_resp_valid}, 64'd0);
      chk("reset result", o_result, 64'd0);
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      chk("idle req_ready", {63'd0, o_req_ready}, 64'd1);

      for (int i = 0; i < 15; i++) begin
         issue(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
         chk({tbl[i].name, " result"}, res, tbl[i].exp);
         chk({tbl[i].name, " latency"}, 64'(lat), 64'(tbl[i].lat));
         take();
         chk({tbl[i].name, " busy after take"}, {63'd0, o_busy}, 64'd0);
      end

      // response held while consumer stalls
      issue(4'd5, 64'd100, 64'd7, res, lat);
      for (int c = 0; c < 5; c++) begin
         chk("hold resp_valid", {63'd0, o_resp_valid}, 64'd1);
         chk("hold result", o_result, 64'd14);
         chk("hold req_ready", {63'd0, o_req_ready}, 64'd0);
         @(posedge i_clk); #1;
      end
      take();
      chk("post-take busy", {63'd0, o_busy}, 64'd0);
      chk("post-take req_ready", {63'd0, o_req_ready}, 64'd1);
      issue(4'd7, 64'd100, 64'd7, res, lat);
      chk("next REMU result", res, 64'd2);
      chk("next REMU latency", 64'(lat), 64'd66);
      take();

      // flush in IDLE blocks acceptance
      i_flush = 1'b1; i_req_valid = 1'b1; i_req_op = 4'd5; i_src1 = 64'd5; i_src2 = 64'd0;
      #1;
      chk("idle flush req_ready", {63'd0, o_req_ready}, 64'd0);
      @(posedge i_clk); #1;
      i_flush = 1'b0; i_req_valid = 1'b0;
      chk("idle flush busy", {63'd0, o_busy}, 64'd0);

      // flush mid-CALC
      i_req_valid = 1'b1; i_req_op = 4'd5; i_src1 = 64'd1000; i_src2 = 64'd7;
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
      repeat (10) @(posedge i_clk);
      #1;
      i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      chk("flush busy", {63'd0, o_busy}, 64'd0);
      seen = 0;
      for (int c = 0; c < 80; c++) begin
         if (o_resp_valid) seen++;
         @(posedge i_clk); #1;
      end
      chk("flush no resp", 64'(seen), 64'd0);
      issue(4'd5, 64'd9, 64'd3, res, lat);
      chk("DIVU 9/3 result", res, 64'd3);
      chk("DIVU 9/3 latency", 64'(lat), 64'd66);
      take();

      // asynchronous reset mid-CALC
      i_req_valid = 1'b1; i_req_op = 4'd0; i_src1 = 64'd6; i_src2 = 64'd7;
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
      repeat (5) @(posedge i_clk);
      #3;
      chk("pre-rst busy", {63'd0, o_busy}, 64'd1);
      i_rst = 1'b1;
      #1;
      chk("rst busy", {63'd0, o_busy}, 64'd0);
      chk("rst resp_valid", {63'd0, o_resp_valid}, 64'd0);
      chk("rst result", o_result, 64'd0);
      chk("rst req_ready", {63'd0, o_req_ready}, 64'd0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      issue(4'd0, 64'd6, 64'd7, res, lat);
      chk("MUL after rst", res, 64'd42);
      take();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
